// File: rtl/foo_arbiter_if.sv
// Bundle of requester, datapath and response signals for foo_arbiter.
// The arbiter connects through the slave modport; the surrounding
// environment (requesters, foo datapath, response consumer) uses master.
interface foo_arbiter_if #(
    parameter int NUM_REQ = 4
);
    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ*64-1:0] req_a;
    logic [NUM_REQ-1:0]    req_ready;
    logic [63:0]           foo_a;
    logic [63:0]           foo_x;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [63:0]           rsp_x;
    logic [2:0]            rsp_id;
    logic                  busy;

    modport master (
        output req_valid,
        output req_a,
        output foo_x,
        output rsp_ready,
        input  req_ready,
        input  foo_a,
        input  rsp_valid,
        input  rsp_x,
        input  rsp_id,
        input  busy
    );

    modport slave (
        input  req_valid,
        input  req_a,
        input  foo_x,
        input  rsp_ready,
        output req_ready,
        output foo_a,
        output rsp_valid,
        output rsp_x,
        output rsp_id,
        output busy
    );
endinterface

// File: rtl/foo_arbiter.sv
// foo_arbiter: round-robin arbiter sharing one foo datapath among NUM_REQ
// requesters, one transaction in flight at a time.
// Flow: IDLE (grant + latch operand) -> ISSUE -> WAIT (FOO_LAT cycles)
//       -> RESP (hold until consumer takes it) -> IDLE.
// Optional watchdog: define FOO_ARBITER_WDOG_EN to add the wdog_err port and
// the TIMEOUT_CYC parameter; a transaction stuck in WAIT/RESP that long is
// abandoned and the stalled requester loses its turn.
module foo_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int FOO_LAT     = 2
`ifdef FOO_ARBITER_WDOG_EN
    ,
    parameter int TIMEOUT_CYC = 64
`endif
) (
    input  logic         clk,
    input  logic         rst_n,
    foo_arbiter_if.slave bus
`ifdef FOO_ARBITER_WDOG_EN
    ,
    output logic         wdog_err
`endif
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [2:0]         lastGrant_q, lastGrant_d;
    logic [3:0]         latCnt_q, latCnt_d;
    logic [63:0]        fooA_q, fooA_d;
    logic [63:0]        rspX_q, rspX_d;
    logic [2:0]         rspId_q, rspId_d;
    logic               rspValid_q, rspValid_d;

    logic [NUM_REQ-1:0] grant;
    logic [NUM_REQ-1:0] candMask;
    logic [2:0]         candIdx;
    logic [2:0]         winnerIdx;
    logic [63:0]        winnerA;
    logic               anyValid;
    logic               accept;

`ifdef FOO_ARBITER_WDOG_EN
    localparam int WDOG_W = $clog2(TIMEOUT_CYC + 1);

    logic [WDOG_W-1:0]  wdogCnt_q, wdogCnt_d;
    logic               wdogErr_q, wdogErr_d;
`endif

    function automatic logic [2:0] rrIndex(input logic [2:0] base, input int offset);
        int sum;
        sum = (int'(base) + offset) % NUM_REQ;
        return 3'(sum);
    endfunction

    // Round-robin search starting one past the last winner; also picks the winner's operand.
    always_comb begin
        grant     = '0;
        candMask  = '0;
        candIdx   = '0;
        winnerIdx = '0;
        winnerA   = '0;
        anyValid  = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            candIdx  = rrIndex(lastGrant_q, k);
            candMask = NUM_REQ'(1) << candIdx;
            if (!anyValid && ((bus.req_valid & candMask) != '0)) begin
                anyValid  = 1'b1;
                winnerIdx = candIdx;
                grant     = candMask;
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                winnerA = bus.req_a[64*i +: 64];
            end
        end
    end

    // Grants are only offered in IDLE and never while reset is held.
    assign accept        = (state_q == IDLE) && anyValid && rst_n;
    assign bus.req_ready = accept ? grant : '0;

    // Next-state and datapath register updates for the transaction FSM.
    always_comb begin
        state_d     = state_q;
        lastGrant_d = lastGrant_q;
        latCnt_d    = latCnt_q;
        fooA_d      = fooA_q;
        rspX_d      = rspX_q;
        rspId_d     = rspId_q;
        rspValid_d  = rspValid_q;
`ifdef FOO_ARBITER_WDOG_EN
        wdogCnt_d   = '0;
        wdogErr_d   = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (accept) begin
                    fooA_d      = winnerA;
                    rspId_d     = winnerIdx;
                    lastGrant_d = winnerIdx;
                    state_d     = ISSUE;
                end
            end
            ISSUE: begin
                latCnt_d = 4'(FOO_LAT - 1);
                state_d  = WAIT;
            end
            WAIT: begin
                if (latCnt_q == 4'd0) begin
                    rspX_d     = bus.foo_x;
                    rspValid_d = 1'b1;
                    state_d    = RESP;
                end else begin
                    latCnt_d = latCnt_q - 4'd1;
                end
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    rspValid_d = 1'b0;
                    state_d    = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
`ifdef FOO_ARBITER_WDOG_EN
        if ((state_q == WAIT) || (state_q == RESP)) begin
            if ((wdogCnt_q == WDOG_W'(TIMEOUT_CYC - 1)) &&
                !((state_q == RESP) && bus.rsp_ready)) begin
                state_d     = IDLE;
                rspValid_d  = 1'b0;
                wdogErr_d   = 1'b1;
                lastGrant_d = rspId_q;
            end else begin
                wdogCnt_d = wdogCnt_q + WDOG_W'(1);
            end
        end
`endif
    end

    // State and datapath registers; reset abandons any transaction in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            lastGrant_q <= 3'(NUM_REQ - 1);
            latCnt_q    <= '0;
            fooA_q      <= '0;
            rspX_q      <= '0;
            rspId_q     <= '0;
            rspValid_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            lastGrant_q <= lastGrant_d;
            latCnt_q    <= latCnt_d;
            fooA_q      <= fooA_d;
            rspX_q      <= rspX_d;
            rspId_q     <= rspId_d;
            rspValid_q  <= rspValid_d;
        end
    end

`ifdef FOO_ARBITER_WDOG_EN
    // Watchdog counter and one-cycle error pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wdogCnt_q <= '0;
            wdogErr_q <= 1'b0;
        end else begin
            wdogCnt_q <= wdogCnt_d;
            wdogErr_q <= wdogErr_d;
        end
    end

    assign wdog_err = wdogErr_q;
`endif

    assign bus.foo_a     = fooA_q;
    assign bus.rsp_x     = rspX_q;
    assign bus.rsp_id    = rspId_q;
    assign bus.rsp_valid = rspValid_q;
    assign bus.busy      = (state_q != IDLE);

endmodule

// File: tb/tb_foo_arbiter.sv
// Directed scoreboard bench for foo_arbiter: grant order, response latency,
// response hold under backpressure, operand stability, and async reset.
module tb_foo_arbiter;

    localparam int NUM_REQ = 4;
    localparam int FOO_LAT = 2;

    typedef struct packed {
        logic [2:0]  id;
        logic [63:0] x;
    } exp_t;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    int          checks   = 0;
    int          failures = 0;
    exp_t        sb[$];
    logic [63:0] expFooA  = '0;
    logic [63:0] fooPipe [FOO_LAT];

    foo_arbiter_if #(.NUM_REQ(NUM_REQ)) bus ();

`ifdef FOO_ARBITER_WDOG_EN
    logic wdogErr;
`endif

    foo_arbiter #(
        .NUM_REQ (NUM_REQ),
        .FOO_LAT (FOO_LAT)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus)
`ifdef FOO_ARBITER_WDOG_EN
        ,
        .wdog_err (wdogErr)
`endif
    );

    // Free-running clock, 10 time units per cycle.
    always #5 clk = ~clk;

    function automatic logic [63:0] fooFunc(input logic [63:0] a);
        return {a[31:0], a[63:32]} ^ 64'hDEAD_BEEF_0BAD_F00D;
    endfunction

    // Behavioural foo datapath: result appears FOO_LAT edges after foo_a.
    always @(posedge clk) begin
        fooPipe[0] <= fooFunc(bus.foo_a);
        for (int i = 1; i < FOO_LAT; i++) begin
            fooPipe[i] <= fooPipe[i-1];
        end
    end
    assign bus.foo_x = fooPipe[FOO_LAT-1];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Offer requests, check the one-hot grant, record the expected response, take the acceptance edge.
    task automatic applyStimulus(input logic [NUM_REQ-1:0] valids, input int expId);
        logic [63:0] op;
        bus.req_valid = valids;
        #1;
        checkOutput("grant", 64'(bus.req_ready), 64'(1) << expId);
        op = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (i == expId) op = bus.req_a[64*i +: 64];
        end
        expFooA = op;
        sb.push_back('{id: 3'(expId), x: fooFunc(op)});
        tick();
        checkOutput("fooALatched", bus.foo_a, expFooA);
        checkOutput("rspIdLatched", 64'(bus.rsp_id), 64'(expId));
        checkOutput("busyActive", 64'(bus.busy), 64'd1);
    endtask

    // Wait (bounded) for the response, check latency and content, optionally hold rsp_ready low.
    task automatic checkResponse(input int holdCycles, input bit scramble);
        int   n;
        exp_t e;
        bus.rsp_ready = (holdCycles == 0);
        n = 0;
        while (bus.rsp_valid !== 1'b1 && n < 50) begin
            checkOutput("readyLowBusy", 64'(bus.req_ready), 64'd0);
            checkOutput("fooAHeld", bus.foo_a, expFooA);
            if (scramble) begin
                for (int i = 0; i < NUM_REQ * 2; i++) bus.req_a[32*i +: 32] = $urandom();
            end
            tick();
            n++;
        end
        checkOutput("latency", 64'(n), 64'(FOO_LAT + 1));
        checkOutput("sbNotEmpty", 64'(sb.size() != 0), 64'd1);
        e = (sb.size() != 0) ? sb.pop_front() : '0;
        checkOutput("rspId", 64'(bus.rsp_id), 64'(e.id));
        checkOutput("rspX", bus.rsp_x, e.x);
        for (int i = 0; i < holdCycles; i++) begin
            tick();
            checkOutput("holdValid", 64'(bus.rsp_valid), 64'd1);
            checkOutput("holdX", bus.rsp_x, e.x);
            checkOutput("holdId", 64'(bus.rsp_id), 64'(e.id));
            checkOutput("holdNoGrant", 64'(bus.req_ready), 64'd0);
        end
        bus.rsp_ready = 1'b1;
        tick();
        checkOutput("rspDone", 64'(bus.rsp_valid), 64'd0);
        checkOutput("idleAfterRsp", 64'(bus.busy), 64'd0);
    endtask

    // Directed sequence.
    initial begin
        bus.req_valid = '1;
        bus.rsp_ready = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            bus.req_a[64*i +: 64] = {32'hA000_0000 + 32'(i), 32'h1234_5678 ^ 32'(i * 7 + 1)};
        end
        #2;
        checkOutput("resetReady", 64'(bus.req_ready), 64'd0);
        checkOutput("resetValid", 64'(bus.rsp_valid), 64'd0);
        checkOutput("resetBusy", 64'(bus.busy), 64'd0);
        checkOutput("resetFooA", bus.foo_a, 64'd0);
        checkOutput("resetRspX", bus.rsp_x, 64'd0);
        checkOutput("resetRspId", 64'(bus.rsp_id), 64'd0);
`ifdef FOO_ARBITER_WDOG_EN
        checkOutput("resetWdog", 64'(wdogErr), 64'd0);
`endif
        tick();
        tick();
        checkOutput("noAcceptInReset", 64'(bus.busy), 64'd0);
        rst_n = 1'b1;

        // All four requesters continuously valid: strict rotation 0,1,2,3,0.
        applyStimulus(4'b1111, 0);
        checkResponse(0, 1'b0);
        applyStimulus(4'b1111, 1);
        checkResponse(0, 1'b1);
        applyStimulus(4'b1111, 2);
        checkResponse(0, 1'b0);
        applyStimulus(4'b1111, 3);
        checkResponse(0, 1'b1);
        applyStimulus(4'b1111, 0);
        checkResponse(0, 1'b0);

        // Single request from requester 0 with a known operand.
        bus.req_a[63:0] = 64'h0000_0000_0000_1234;
        applyStimulus(4'b0001, 0);
        bus.req_valid = '0;
        checkResponse(0, 1'b0);

        // Consumer backpressure for 10 cycles while requester 2 keeps asking.
        applyStimulus(4'b0100, 2);
        checkResponse(10, 1'b1);

        // Request withdrawn before the grant edge: nothing accepted; rsp_ready alone does nothing.
        bus.req_valid = 4'b0010;
        #1;
        checkOutput("grantBeforeDrop", 64'(bus.req_ready), 64'b0010);
        #2;
        bus.req_valid = '0;
        tick();
        checkOutput("noAcceptBusy", 64'(bus.busy), 64'd0);
        checkOutput("noAcceptFooA", bus.foo_a, expFooA);
        checkOutput("noRspWhileIdle", 64'(bus.rsp_valid), 64'd0);

        // Reset pulsed during WAIT abandons the transaction and restores priority.
        applyStimulus(4'b0010, 1);
        bus.req_valid = '1;
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("asyncBusy", 64'(bus.busy), 64'd0);
        checkOutput("asyncFooA", bus.foo_a, 64'd0);
        checkOutput("asyncRspX", bus.rsp_x, 64'd0);
        checkOutput("asyncRspId", 64'(bus.rsp_id), 64'd0);
        checkOutput("asyncValid", 64'(bus.rsp_valid), 64'd0);
        checkOutput("asyncReady", 64'(bus.req_ready), 64'd0);
        void'(sb.pop_back());
        tick();
        tick();
        checkOutput("abandonedNoRsp", 64'(bus.rsp_valid), 64'd0);
        rst_n = 1'b1;
        applyStimulus(4'b1100, 2);
        bus.req_valid = '0;
        checkResponse(0, 1'b0);
        applyStimulus(4'b1011, 3);
        bus.req_valid = '0;
        checkResponse(0, 1'b1);
        checkOutput("sbDrained", 64'(sb.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

    // Hard stop in case the sequence ever stalls.
    initial begin
        #200000;
        $display("[TB] FAIL globalTimeout: still running at %0t, required to finish earlier", $time);
        $fatal(1, "[TB] simulation time limit reached");
    end

endmodule

// File: doc/foo_arbiter.md
FOO_ARBITER -- requirements
Module: foo_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4: number of requesters sharing one foo datapath instance; legal range 2..8.
REQ-002 Parameter FOO_LAT, default 2: cycles from driving foo_a until foo_x is valid; legal range 1..15.
REQ-003 Parameter TIMEOUT_CYC, default 64: watchdog limit in cycles; used only when FOO_ARBITER_WDOG_EN is defined.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 req_valid  input  NUM_REQ  per-requester request strobe.
REQ-007 req_a  input  NUM_REQ*64  per-requester operand; slice i = bits [64*i+63:64*i].
REQ-008 req_ready  output  NUM_REQ  one-hot grant; a request is accepted when req_valid[i] and req_ready[i] are both high.
REQ-009 foo_a  output  64  operand driven to the foo datapath.
REQ-010 foo_x  input  64  result from the foo datapath.
REQ-011 rsp_valid  output  1  response available.
REQ-012 rsp_ready  input  1  response consumer ready.
REQ-013 rsp_x  output  64  captured foo_x.
REQ-014 rsp_id  output  3  index of the requester that owns rsp_x.
REQ-015 busy  output  1  high whenever the FSM is not in IDLE.

Function
REQ-016 FSM states: IDLE, ISSUE, WAIT, RESP; the FSM SHALL hold exactly one transaction at a time.
REQ-017 IDLE: if any req_valid is high, assert req_ready for the round-robin winner in the same cycle; on acceptance, latch req_a into foo_a, latch the winner into rsp_id, and go to ISSUE.
REQ-018 Round-robin: search starts at (last_grant+1) mod NUM_REQ; last_grant resets to NUM_REQ-1, so requester 0 has first priority.
REQ-019 ISSUE lasts one cycle; it loads the latency counter with FOO_LAT-1 and goes to WAIT.
REQ-020 WAIT decrements the counter; at zero, capture foo_x into rsp_x, assert rsp_valid, and go to RESP.
REQ-021 Acceptance-to-rsp_valid latency SHALL be exactly FOO_LAT+1 cycles.
REQ-022 foo_a SHALL hold its value from acceptance until the next acceptance, never changing mid-transaction.
REQ-023 RESP: rsp_valid, rsp_x and rsp_id SHALL hold stable until rsp_valid and rsp_ready are both high; the FSM then returns to IDLE.
REQ-024 req_ready SHALL be all-zero outside IDLE; there SHALL be no back-to-back acceptance, so the minimum period is FOO_LAT+3 cycles per transaction.
REQ-025 Requester deasserting req_valid before grant: no acceptance, no state change.
REQ-026 rsp_ready high before rsp_valid SHALL have no effect.
REQ-027 rsp_id width is fixed at 3; unused upper bits SHALL be zero.

Reset
REQ-028 On assertion of rst_n low, immediately and independent of clk, the block SHALL enter:
- FSM = IDLE
- req_ready = 0, rsp_valid = 0, busy = 0
- foo_a = 0, rsp_x = 0, rsp_id = 0
- last_grant = NUM_REQ-1, counters = 0
REQ-029 Reset asserted mid-transaction SHALL abandon that transaction with no response.
REQ-030 The first acceptance after rst_n deasserts SHALL occur no earlier than the first rising clk edge with rst_n high.

Configuration
REQ-031 Macro FOO_ARBITER_WDOG_EN defined: a counter runs in WAIT and RESP. If TIMEOUT_CYC cycles elapse without completion, the FSM SHALL force IDLE, drop rsp_valid, pulse output wdog_err (1 bit, reset 0) high for one cycle, and advance last_grant past the stalled requester.
REQ-032 Macro FOO_ARBITER_WDOG_EN undefined: no wdog_err port and no watchdog logic; RESP waits indefinitely.

Verification
REQ-033 Single request: req_valid=0001, req_a[0]=0x1234, FOO_LAT=2, rsp_ready=1 -> rsp_valid rises 3 cycles after acceptance with rsp_id=0 and rsp_x equal to foo_x sampled at WAIT end.
REQ-034 All four requesters held valid continuously -> grant order 0,1,2,3,0; each rsp_id matches its grant.
REQ-035 rsp_ready held 0 for 10 cycles in RESP -> rsp_valid, rsp_x and rsp_id stable; req_ready=0 throughout; completion on the cycle rsp_ready=1.
REQ-036 rst_n pulsed low during WAIT -> all outputs zero asynchronously; next request to requester 2 granted first only if requesters 0 and 1 are idle.
REQ-037 With FOO_ARBITER_WDOG_EN and TIMEOUT_CYC=64: rsp_ready stuck at 0 -> wdog_err pulses once at cycle 64, FSM returns to IDLE, and the next grant skips the stalled requester.
REQ-038 Vary foo_a while in WAIT by changing req_a inputs -> foo_a unchanged until the next acceptance.
